// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

   localparam int XLEN = 32;
   localparam int ILEN = 32;

   localparam logic [XLEN-1:0] FETCH_STEP_PAIR = 32'd8;
   localparam logic [XLEN-1:0] FETCH_STEP_ONE  = 32'd4;

   typedef struct packed {
      logic [ILEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular buffer of fetched entries: accepts 0..2 pushes and 1 pop per cycle, flushable.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       push_cnt,
   input  fetch_entry_t     push0,
   input  fetch_entry_t     push1,
   input  logic             pop,
   input  logic             flush,
   output fetch_entry_t     head,
   output logic [CNT_W-1:0] cnt
);

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] wr_ptr_1;

   assign wr_ptr_1 = wr_ptr + PTR_W'(1);
   assign head     = mem[rd_ptr];

   // NOTE: storage is reset too, so the head reads as zero straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_cnt != 2'd0) mem[wr_ptr]   <= push0;
         if (push_cnt == 2'd2) mem[wr_ptr_1] <= push1;
         wr_ptr <= wr_ptr + PTR_W'(push_cnt);
         rd_ptr <= rd_ptr + PTR_W'(pop);
         cnt    <= cnt + CNT_W'(push_cnt) - CNT_W'(pop);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end driving a dual-port imem and feeding decode.
// Optional perf counters enabled by defining FETCH_PERF_EN.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_a,
   input  logic [31:0] imem_rd1,
   input  logic [31:0] imem_rd2,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_issued,
   output logic [31:0] perf_starve
`endif
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [31:0]      pc;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] free;
   logic [1:0]       push_cnt;
   logic             deq;
   fetch_entry_t     head;
   fetch_entry_t     push0;
   fetch_entry_t     push1;

   assign free      = CNT_W'(DEPTH) - cnt;
   assign out_valid = (cnt != '0);
   assign deq       = out_valid & out_ready;
   assign imem_a    = pc;
   assign out_instr = head.instr;
   assign out_pc    = head.pc;
   assign push0     = '{instr: imem_rd1, pc: pc};
   assign push1     = '{instr: imem_rd2, pc: pc + FETCH_STEP_ONE};

   // Space is judged on current occupancy only; a same-cycle pop is not credited.
   // NOTE: push_cnt gets a default first so every path assigns it and no latch forms.
   always_comb begin
      push_cnt = 2'd0;
      if (!redirect_valid) begin
         if (free >= CNT_W'(2))      push_cnt = 2'd2;
         else if (free == CNT_W'(1)) push_cnt = 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              pc <= align_word(RESET_PC);
      else if (redirect_valid) pc <= align_word(redirect_pc);
      else if (push_cnt == 2'd2) pc <= pc + FETCH_STEP_PAIR;
      else if (push_cnt == 2'd1) pc <= pc + FETCH_STEP_ONE;
   end

   fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk      (clk),
      .rst_n    (rst_n),
      .push_cnt (push_cnt),
      .push0    (push0),
      .push1    (push1),
      .pop      (deq),
      .flush    (redirect_valid),
      .head     (head),
      .cnt      (cnt)
   );

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_issued <= '0;
         perf_starve <= '0;
      end else begin
         if (deq)                     perf_issued <= perf_issued + 32'd1;
         if (!out_valid && out_ready) perf_starve <= perf_starve + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table, directed corner sequences, random vs queue model.
module tb_fetch_unit;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] imem_a;
   logic [31:0] imem_rd1;
   logic [31:0] imem_rd2;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_issued;
   logic [31:0] perf_starve;
`endif

   fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_a         (imem_a),
      .imem_rd1       (imem_rd1),
      .imem_rd2       (imem_rd2),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc)
`ifdef FETCH_PERF_EN
      ,
      .perf_issued    (perf_issued),
      .perf_starve    (perf_starve)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] imem_word(input logic [31:0] a);
      case (a)
         32'd0:   return 32'h0240_0413;
         32'd4:   return 32'h0040_0493;
         32'd8:   return 32'h0094_0333;
         32'd12:  return 32'h0070_0913;
         32'd56:  return 32'h0630_0913;
         32'd60:  return 32'h0129_A0A3;
         default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
      endcase
   endfunction

   assign imem_rd1 = imem_word(imem_a);
   assign imem_rd2 = imem_word(imem_a + 32'd4);

   // Reference model: queue of fetched addresses; instruction is implied by imem_word(pc).
   logic [31:0] mq [$];
   logic [31:0] mpc;
   int unsigned m_issued;
   int unsigned m_starve;
   int          n_checks = 0;
   int          n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      check("valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
      if (mq.size() != 0) begin
         check("out_pc", out_pc, mq[0]);
         check("out_instr", out_instr, imem_word(mq[0]));
      end
      check("imem_a", imem_a, mpc);
`ifdef FETCH_PERF_EN
      check("perf_issued", perf_issued, m_issued);
      check("perf_starve", perf_starve, m_starve);
`endif
   endtask

   task automatic cycle(input logic rdy, input logic redir, input logic [31:0] rpc);
      int size0;
      int n;
      out_ready      = rdy;
      redirect_valid = redir;
      redirect_pc    = rpc;
      size0 = mq.size();
      if (size0 != 0 && rdy) m_issued++;
      if (size0 == 0 && rdy) m_starve++;
      if (redir) begin
         mq.delete();
         mpc = rpc & 32'hFFFF_FFFC;
      end else begin
         if (size0 != 0 && rdy) void'(mq.pop_front());
         n = (DEPTH - size0 >= 2) ? 2 : DEPTH - size0;
         for (int k = 0; k < n; k++) begin
            mq.push_back(mpc);
            mpc = mpc + 32'd4;
         end
      end
      @(posedge clk);
      #1;
      compare_model();
   endtask

   task automatic do_reset(input logic rdy);
      rst_n          = 1'b0;
      out_ready      = rdy;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      repeat (2) @(negedge clk);
      mq.delete();
      mpc      = RESET_PC & 32'hFFFF_FFFC;
      m_issued = 0;
      m_starve = 0;
      rst_n    = 1'b1;
      #1;
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_instr", out_instr, 32'd0);
      check("rst_pc", out_pc, 32'd0);
      check("rst_imem_a", imem_a, RESET_PC);
   endtask

   typedef struct {
      logic        rdy;
      logic [31:0] exp_pc;
      logic [31:0] exp_instr;
      logic [31:0] exp_a;
   } vec_t;

   vec_t vecs [4];

   initial begin
      vecs[0] = '{1'b1, 32'd0,  32'h0240_0413, 32'd8};
      vecs[1] = '{1'b1, 32'd4,  32'h0040_0493, 32'd16};
      vecs[2] = '{1'b1, 32'd8,  32'h0094_0333, 32'd20};
      vecs[3] = '{1'b1, 32'd12, 32'h0070_0913, 32'd24};

      // Reset release with decode always ready.
      do_reset(1'b1);
      for (int i = 0; i < 4; i++) begin
         cycle(vecs[i].rdy, 1'b0, 32'd0);
         check("tbl_valid", {31'd0, out_valid}, 32'd1);
         check("tbl_pc", out_pc, vecs[i].exp_pc);
         check("tbl_instr", out_instr, vecs[i].exp_instr);
         check("tbl_imem_a", imem_a, vecs[i].exp_a);
      end

      // Decode stalled: fill to DEPTH, then pc holds; redirect while full.
      do_reset(1'b0);
      cycle(1'b0, 1'b0, 32'd0);
      check("stall_a1", imem_a, 32'd8);
      cycle(1'b0, 1'b0, 32'd0);
      check("stall_a2", imem_a, 32'd16);
      cycle(1'b0, 1'b0, 32'd0);
      check("stall_hold_a", imem_a, 32'd16);
      check("stall_hold_instr", out_instr, 32'h0240_0413);
      cycle(1'b1, 1'b1, 32'd58);
      check("redir_valid", {31'd0, out_valid}, 32'd0);
      check("redir_a", imem_a, 32'd56);
      cycle(1'b1, 1'b0, 32'd0);
      check("redir_pc0", out_pc, 32'd56);
      check("redir_instr0", out_instr, 32'h0630_0913);
      cycle(1'b1, 1'b0, 32'd0);
      check("redir_pc1", out_pc, 32'd60);
      check("redir_instr1", out_instr, 32'h0129_A0A3);

      // Single push when exactly one slot is free, then drain across pointer wrap.
      do_reset(1'b0);
      cycle(1'b0, 1'b0, 32'd0);
      cycle(1'b1, 1'b0, 32'd0);
      check("one_a_pre", imem_a, 32'd16);
      cycle(1'b0, 1'b0, 32'd0);
      check("one_a", imem_a, 32'd20);
      check("one_head", out_pc, 32'd4);
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'd0);

      // pc wraps modulo 2^32.
      cycle(1'b0, 1'b1, 32'hFFFF_FFF8);
      cycle(1'b1, 1'b0, 32'd0);
      check("wrap_a", imem_a, 32'd0);
      check("wrap_head", out_pc, 32'hFFFF_FFF8);
      cycle(1'b1, 1'b0, 32'd0);
      check("wrap_next", out_pc, 32'hFFFF_FFFC);

`ifdef FETCH_PERF_EN
      do_reset(1'b1);
      cycle(1'b1, 1'b0, 32'd0);
      for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 32'd0);
      cycle(1'b0, 1'b1, 32'h100);
      cycle(1'b1, 1'b0, 32'd0);
      cycle(1'b0, 1'b1, 32'h200);
      cycle(1'b1, 1'b0, 32'd0);
      check("perf_issued_10", perf_issued, 32'd10);
      check("perf_starve_3", perf_starve, 32'd3);
`endif

      // Random traffic against the queue model.
      do_reset(1'b0);
      for (int i = 0; i < 400; i++) begin
         logic        rdy;
         logic        rd;
         logic [31:0] rpc;
         rdy = ($urandom_range(0, 9) < 7);
         rd  = ($urandom_range(0, 19) == 0);
         rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                           : $urandom;
         cycle(rdy, rd, rpc);
      end

      // Asynchronous reset mid-cycle with entries queued.
      cycle(1'b0, 1'b0, 32'd0);
      cycle(1'b0, 1'b0, 32'd0);
      check("async_pre_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_valid", {31'd0, out_valid}, 32'd0);
      check("async_imem_a", imem_a, RESET_PC);
      do_reset(1'b1);
      cycle(1'b1, 1'b0, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
